// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared types and helpers for the mem_dp_lanes lane-masked dual-port RAM.
//   mem_state_e  : clear-engine state (ST_CLEAR while initialising, ST_READY
//                  while the user ports are live)
//   COLLIDE_RF   : collision policy value, read-first (old word returned)
//   COLLIDE_WF   : collision policy value, write-first (masked forwarding)
//   lane_merge() : per-lane select between an old word and a new word
// -----------------------------------------------------------------------------
package mem_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } mem_state_e;

    localparam int unsigned COLLIDE_RF = 0;
    localparam int unsigned COLLIDE_WF = 1;

    // Upper bounds for lane_merge(); a RAM instance must keep
    // LANES <= MAX_LANES and LANES*LANE_W <= MAX_DATA_W.
    localparam int unsigned MAX_LANES  = 16;
    localparam int unsigned LANE_IDX_W = 4;
    localparam int unsigned MAX_DATA_W = 256;

    // Bit b belongs to lane b/lane_w; that bit comes from new_w when the
    // lane's mask bit is set, otherwise from old_w. Callers zero-extend their
    // operands to MAX_DATA_W and truncate the result back to their width.
    function automatic logic [MAX_DATA_W-1:0] lane_merge(
        input logic [MAX_DATA_W-1:0] old_w,
        input logic [MAX_DATA_W-1:0] new_w,
        input logic [MAX_LANES-1:0]  mask,
        input int unsigned           lane_w
    );
        logic [MAX_DATA_W-1:0] res;
        int unsigned           lane;
        res = old_w;
        for (int unsigned b = 0; b < MAX_DATA_W; b++) begin
            lane = b / lane_w;
            if (lane < MAX_LANES) begin
                if (mask[lane[LANE_IDX_W-1:0]]) begin
                    res[b] = new_w[b];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_clear_ctrl.sv
// -----------------------------------------------------------------------------
// mem_clear_ctrl
// Clear engine for mem_dp_lanes: walks every word address once after reset or
// after a clear request, then hands the array to the user ports.
// Ports:
//   clk_i      : clock, rising edge
//   rst_i      : synchronous active-high reset, restarts the walk at address 0
//   clr_req_i  : single-cycle request to re-run the walk (ignored while busy)
//   state_o    : current engine state (ST_CLEAR / ST_READY)
//   busy_o     : registered, high for exactly DEPTH cycles per walk
//   clr_we_o   : write strobe for the array, high in ST_CLEAR
//   clr_ptr_o  : word address being initialised this cycle
// -----------------------------------------------------------------------------
module mem_clear_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_req_i,
    output mem_state_e        state_o,
    output logic              busy_o,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_ptr_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    mem_state_e        state_q;
    logic              busy_q;
    logic [ADDR_W-1:0] ptr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_CLEAR;
            busy_q  <= 1'b1;
            ptr_q   <= '0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    // The last word is written this cycle; ports open next.
                    if (ptr_q == LAST_ADDR) begin
                        state_q <= ST_READY;
                        busy_q  <= 1'b0;
                        ptr_q   <= '0;
                    end else begin
                        ptr_q <= ptr_q + 1'b1;
                    end
                end
                ST_READY: begin
                    if (clr_req_i) begin
                        state_q <= ST_CLEAR;
                        busy_q  <= 1'b1;
                        ptr_q   <= '0;
                    end
                end
                default: begin
                    state_q <= ST_CLEAR;
                    busy_q  <= 1'b1;
                    ptr_q   <= '0;
                end
            endcase
        end
    end

    assign state_o   = state_q;
    assign busy_o    = busy_q;
    assign clr_we_o  = (state_q == ST_CLEAR);
    assign clr_ptr_o = ptr_q;

endmodule

// File: rtl/mem_dp_lanes.sv
// -----------------------------------------------------------------------------
// mem_dp_lanes
// Simple dual-port (1 write / 1 read) synchronous RAM with per-lane write
// masks, a read-valid strobe, a defined read-during-write policy and a clear
// engine that fills the array with INIT_VAL after reset or on request.
// Optional build macro: MEM_OUT_REG_EN adds an output register stage (read
// latency 2, D_VALID delayed to match, stage cleared by RST).
// Ports:
//   CK       : clock, rising edge
//   RST      : synchronous active-high reset
//   CS       : chip select, gates both ports
//   WE / RE  : write / read enable (honoured only while not BUSY)
//   W_ADDR   : write word address (>= DEPTH drops the write)
//   R_ADDR   : read word address (>= DEPTH reads all zeros)
//   W_MASK   : per-lane write enable
//   D_IN     : write data
//   CLR_REQ  : re-run the clear engine
//   D_OUT    : read data, holds between reads
//   D_VALID  : one-cycle strobe qualifying D_OUT
//   BUSY     : clear engine running, user ports ignored
// -----------------------------------------------------------------------------
module mem_dp_lanes
    import mem_pkg::*;
#(
    parameter int unsigned       LANES      = 3,
    parameter int unsigned       LANE_W     = 8,
    parameter int unsigned       DEPTH      = 1024,
    parameter logic [LANE_W-1:0] INIT_VAL   = '0,
    parameter int unsigned       COLLIDE_WF = 0,
    localparam int unsigned      DATA_W     = LANES * LANE_W,
    localparam int unsigned      ADDR_W     = $clog2(DEPTH)
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              CS,
    input  logic              WE,
    input  logic              RE,
    input  logic [ADDR_W-1:0] W_ADDR,
    input  logic [ADDR_W-1:0] R_ADDR,
    input  logic [LANES-1:0]  W_MASK,
    input  logic [DATA_W-1:0] D_IN,
    input  logic              CLR_REQ,
    output logic [DATA_W-1:0] D_OUT,
    output logic              D_VALID,
    output logic              BUSY
);

    mem_state_e        state;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_ptr;

    mem_clear_ctrl #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear (
        .clk_i     (CK),
        .rst_i     (RST),
        .clr_req_i (CLR_REQ),
        .state_o   (state),
        .busy_o    (BUSY),
        .clr_we_o  (clr_we),
        .clr_ptr_o (clr_ptr)
    );

    logic [DATA_W-1:0] mem [DEPTH];

    logic              ready;
    logic              w_in_range;
    logic              r_in_range;
    logic              wr_en;
    logic              rd_en;
    logic              collide;
    logic [DATA_W-1:0] wr_word;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] rd_data;

    assign ready      = (state == ST_READY);
    assign w_in_range = (32'(W_ADDR) < DEPTH);
    assign r_in_range = (32'(R_ADDR) < DEPTH);
    assign wr_en      = ready & CS & WE & w_in_range & (|W_MASK);
    assign rd_en      = ready & CS & RE;
    assign collide    = wr_en & rd_en & (W_ADDR == R_ADDR);

    // Unmasked lanes keep their stored value.
    assign wr_word = DATA_W'(lane_merge(MAX_DATA_W'(mem[W_ADDR]),
                                        MAX_DATA_W'(D_IN),
                                        MAX_LANES'(W_MASK),
                                        LANE_W));

    assign rd_word = r_in_range ? mem[R_ADDR] : '0;

    // Write-first forwards only the lanes being written this cycle.
    always_comb begin
        rd_data = rd_word;
        if ((COLLIDE_WF == mem_pkg::COLLIDE_WF) && collide) begin
            rd_data = DATA_W'(lane_merge(MAX_DATA_W'(rd_word),
                                         MAX_DATA_W'(D_IN),
                                         MAX_LANES'(W_MASK),
                                         LANE_W));
        end
    end

    // Array has no reset; the clear engine owns it while BUSY.
    always_ff @(posedge CK) begin
        if (clr_we) begin
            mem[clr_ptr] <= {LANES{INIT_VAL}};
        end else if (wr_en) begin
            mem[W_ADDR] <= wr_word;
        end
    end

    logic [DATA_W-1:0] d_out_d;
    logic [DATA_W-1:0] d_out_q;
    logic              d_valid_d;
    logic              d_valid_q;

    always_comb begin
        d_out_d   = d_out_q;
        d_valid_d = rd_en;
        if (rd_en) begin
            d_out_d = rd_data;
        end
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            d_out_q   <= '0;
            d_valid_q <= 1'b0;
        end else begin
            d_out_q   <= d_out_d;
            d_valid_q <= d_valid_d;
        end
    end

`ifdef MEM_OUT_REG_EN
    logic [DATA_W-1:0] d_out2_q;
    logic              d_valid2_q;

    // Second stage only loads on a valid first-stage word so D_OUT holds.
    always_ff @(posedge CK) begin
        if (RST) begin
            d_out2_q   <= '0;
            d_valid2_q <= 1'b0;
        end else begin
            d_valid2_q <= d_valid_q;
            if (d_valid_q) begin
                d_out2_q <= d_out_q;
            end
        end
    end

    assign D_OUT   = d_out2_q;
    assign D_VALID = d_valid2_q;
`else
    assign D_OUT   = d_out_q;
    assign D_VALID = d_valid_q;
`endif

endmodule

// File: tb/tb_mem_dp_lanes.sv
// -----------------------------------------------------------------------------
// tb_mem_dp_lanes
// Two instances share one stimulus stream: inst0 is 1024 deep read-first,
// inst1 is 600 deep write-first. A per-instance array model predicts BUSY,
// D_VALID and D_OUT every cycle; directed sequences pin literal values.
// -----------------------------------------------------------------------------
module tb_mem_dp_lanes;

`ifdef MEM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int unsigned DEP0 = 1024;
    localparam int unsigned DEP1 = 600;

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst     = 1'b1;
    logic        cs      = 1'b0;
    logic        we      = 1'b0;
    logic        re      = 1'b0;
    logic        clr_req = 1'b0;
    logic [9:0]  w_addr  = '0;
    logic [9:0]  r_addr  = '0;
    logic [2:0]  w_mask  = '0;
    logic [23:0] d_in    = '0;

    logic [23:0] d_out0, d_out1;
    logic        valid0, valid1, busy0, busy1;

    mem_dp_lanes #(
        .LANES(3), .LANE_W(8), .DEPTH(DEP0), .INIT_VAL(8'h00), .COLLIDE_WF(0)
    ) dut0 (
        .CK(clk), .RST(rst), .CS(cs), .WE(we), .RE(re),
        .W_ADDR(w_addr), .R_ADDR(r_addr), .W_MASK(w_mask), .D_IN(d_in),
        .CLR_REQ(clr_req), .D_OUT(d_out0), .D_VALID(valid0), .BUSY(busy0)
    );

    mem_dp_lanes #(
        .LANES(3), .LANE_W(8), .DEPTH(DEP1), .INIT_VAL(8'h00), .COLLIDE_WF(1)
    ) dut1 (
        .CK(clk), .RST(rst), .CS(cs), .WE(we), .RE(re),
        .W_ADDR(w_addr), .R_ADDR(r_addr), .W_MASK(w_mask), .D_IN(d_in),
        .CLR_REQ(clr_req), .D_OUT(d_out1), .D_VALID(valid1), .BUSY(busy1)
    );

    // ---------------- counters / check ----------------
    int n_vec  = 0;
    int n_err  = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [23:0] m_mem [2][1024];
    int          busy_left [2];
    logic [23:0] exp_d [2];
    logic        exp_v [2];
    logic [24:0] exp_q0[$];
    logic [24:0] exp_q1[$];

    task automatic model_step(input int k);
        int unsigned dep;
        bit          rdy, rd, wr;
        logic [23:0] rdata;
        logic [24:0] ent;
        dep = (k == 0) ? DEP0 : DEP1;
        if (rst) begin
            for (int a = 0; a < 1024; a++) m_mem[k][a] = '0;
            busy_left[k] = int'(dep);
            if (k == 0) exp_q0.delete(); else exp_q1.delete();
            exp_d[k] = '0;
            exp_v[k] = 1'b0;
        end else begin
            rdy = (busy_left[k] == 0);
            if (!rdy) busy_left[k]--;
            rd = rdy && cs && re;
            wr = rdy && cs && we && (32'(w_addr) < dep);
            rdata = (32'(r_addr) < dep) ? m_mem[k][r_addr] : 24'h0;
            if (k == 1 && rd && wr && (w_addr == r_addr)) begin
                for (int l = 0; l < 3; l++)
                    if (w_mask[l]) rdata[l*8 +: 8] = d_in[l*8 +: 8];
            end
            if (wr) begin
                for (int l = 0; l < 3; l++)
                    if (w_mask[l]) m_mem[k][w_addr][l*8 +: 8] = d_in[l*8 +: 8];
            end
            if (rdy && clr_req) begin
                for (int a = 0; a < 1024; a++) m_mem[k][a] = '0;
                busy_left[k] = int'(dep);
            end
            ent = {rd, rdata};
            if (k == 0) begin
                exp_q0.push_back(ent);
                if (exp_q0.size() >= LAT) begin
                    ent = exp_q0.pop_front();
                    exp_v[k] = ent[24];
                    if (ent[24]) exp_d[k] = ent[23:0];
                end
            end else begin
                exp_q1.push_back(ent);
                if (exp_q1.size() >= LAT) begin
                    ent = exp_q1.pop_front();
                    exp_v[k] = ent[24];
                    if (ent[24]) exp_d[k] = ent[23:0];
                end
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy0",  busy0,  busy_left[0] != 0);
            chk("valid0", valid0, exp_v[0]);
            chk("dout0",  d_out0, exp_d[0]);
            chk("busy1",  busy1,  busy_left[1] != 0);
            chk("valid1", valid1, exp_v[1]);
            chk("dout1",  d_out1, exp_d[1]);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cs = 1'b0; we = 1'b0; re = 1'b0; clr_req = 1'b0; rst = 1'b0;
    endtask

    function automatic logic [9:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return 10'($urandom_range(0, 1023));
            1:       return 10'($urandom_range(590, 610));
            default: return 10'($urandom_range(0, 15));
        endcase
    endfunction

    task automatic write(input logic [9:0] a, input logic [23:0] d, input logic [2:0] m);
        cs = 1'b1; we = 1'b1; re = 1'b0; w_addr = a; d_in = d; w_mask = m;
        tick();
        idle();
    endtask

    task automatic read_check(input string name, input logic [9:0] a,
                              input logic [23:0] e0, input logic [23:0] e1);
        cs = 1'b1; we = 1'b0; re = 1'b1; r_addr = a;
        tick();
        idle();
        repeat (LAT - 1) tick();
        chk({name, "_v0"}, valid0, 1'b1);
        chk({name, "_d0"}, d_out0, e0);
        chk({name, "_v1"}, valid1, 1'b1);
        chk({name, "_d1"}, d_out1, e1);
    endtask

    // Counts BUSY-high cycles of both instances until both drop.
    task automatic run_clear(input bit with_reads, output int n0, output int n1);
        int  g;
        bit  b0;
        n0 = 0; n1 = 0; g = 0;
        while ((busy0 === 1'b1 || busy1 === 1'b1) && g < 3000) begin
            if (busy0 === 1'b1) n0++;
            if (busy1 === 1'b1) n1++;
            if (with_reads) begin
                cs = 1'b1; re = 1'b1; r_addr = 10'($urandom_range(0, 1023));
            end
            b0 = (busy0 === 1'b1);
            g++;
            tick();
            if (with_reads && b0) chk("no_valid_busy", valid0, 1'b0);
        end
        idle();
    endtask

    // ---------------- directed + random stimulus ----------------
    int n0, n1;

    initial begin
        rst = 1'b1;
        tick();
        chk_en = 1'b1;
        idle();

        run_clear(1'b0, n0, n1);
        chk("busy_len0", n0, 1024);
        chk("busy_len1", n1, 600);

        read_check("rd0",    10'd0,    24'h000000, 24'h000000);
        read_check("rd511",  10'd511,  24'h000000, 24'h000000);
        read_check("rd1023", 10'd1023, 24'h000000, 24'h000000);

        write(10'd5, 24'hAABBCC, 3'b111);
        write(10'd5, 24'h112233, 3'b010);
        read_check("mask5", 10'd5, 24'hAA22CC, 24'hAA22CC);

        write(10'd9, 24'h010203, 3'b111);
        cs = 1'b1; we = 1'b1; re = 1'b1; w_addr = 10'd9; r_addr = 10'd9;
        d_in = 24'hFFEEDD; w_mask = 3'b101;
        tick();
        idle();
        repeat (LAT - 1) tick();
        chk("coll_rf", d_out0, 24'h010203);
        chk("coll_wf", d_out1, 24'hFF02DD);
        read_check("after_coll", 10'd9, 24'hFF02DD, 24'hFF02DD);

        // back-to-back reads: 5 then 9, data in issue order
        for (int c = 0; c < LAT + 2; c++) begin
            idle();
            if (c < 2) begin
                cs = 1'b1; re = 1'b1; r_addr = (c == 0) ? 10'd5 : 10'd9;
            end
            tick();
            if (c == LAT - 1) begin
                chk("b2b_v_a", valid0, 1'b1);
                chk("b2b_d_a", d_out0, 24'hAA22CC);
            end
            if (c == LAT) begin
                chk("b2b_v_b", valid0, 1'b1);
                chk("b2b_d_b", d_out0, 24'hFF02DD);
            end
        end
        idle();

        write(10'd700, 24'h5A5A5A, 3'b111);
        read_check("oor700", 10'd700, 24'h5A5A5A, 24'h000000);
        write(10'd599, 24'h0000AB, 3'b111);
        read_check("top599", 10'd599, 24'h0000AB, 24'h0000AB);

        write(10'd7, 24'h123456, 3'b111);
        read_check("pre_clr7", 10'd7, 24'h123456, 24'h123456);
        clr_req = 1'b1;
        tick();
        idle();
        run_clear(1'b1, n0, n1);
        chk("clr_len0", n0, 1024);
        chk("clr_len1", n1, 600);
        read_check("post_clr7", 10'd7, 24'h000000, 24'h000000);

        // reset landing in the middle of a clear walk
        write(10'd3, 24'hC0FFEE, 3'b111);
        rst = 1'b1;
        tick();
        idle();
        chk("rst_dout", d_out0, 24'h000000);
        chk("rst_valid", valid0, 1'b0);
        repeat (300) tick();
        rst = 1'b1;
        tick();
        idle();
        run_clear(1'b0, n0, n1);
        chk("rst300_len0", n0, 1024);
        chk("rst300_len1", n1, 600);
        read_check("post_rst3", 10'd3, 24'h000000, 24'h000000);

        for (int i = 0; i < 6000; i++) begin
            rst     = ($urandom_range(0, 2999) == 0);
            clr_req = ($urandom_range(0, 1999) == 0);
            cs      = ($urandom_range(0, 7) != 0);
            we      = 1'($urandom_range(0, 1));
            re      = 1'($urandom_range(0, 1));
            w_addr  = rand_addr();
            r_addr  = ($urandom_range(0, 3) == 0) ? w_addr : rand_addr();
            w_mask  = 3'($urandom_range(0, 7));
            d_in    = 24'($urandom);
            tick();
        end
        idle();
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #3000000;
        n_err++;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
